leaf_stream_arbiter: RTL and testbench
======================================

# leaf_stream_arbiter

Round-robin arbiter sharing one leaf interface user input port (the user→interface vld/ack stream feeding the BFT packetizer) among several user-side producer streams. It sits between a page's operator outputs and the leaf interface, granting one requester at a time for bursts of up to `BURST_LEN` words. Only the interface-side handshake is touched; packetization, addressing and credit flow stay in the leaf interface.

## Interface
- `NUM_REQ`, 4, number of requester streams (2..16)
- `PAYLOAD_BITS`, 32, word width
- `REQ_ID_BITS`, 2, width of grant index; must satisfy 2^REQ_ID_BITS ≥ NUM_REQ
- `BURST_LEN`, 16, max words per grant before forced rotation (≥1)

- `clk`  in  1  single clock, all logic rising-edge
- `reset`  in  1  asynchronous, active-high
- `req_din`  in  NUM_REQ*PAYLOAD_BITS  requester words; requester i at bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- `req_vld`  in  NUM_REQ  per-requester valid
- `req_ack`  out  NUM_REQ  per-requester accept
- `dout_arb2interface`  out  PAYLOAD_BITS  word to leaf interface
- `vld_arb2interface`  out  1  valid to leaf interface
- `ack_interface2arb`  in  1  accept from leaf interface
- `grant_id`  out  REQ_ID_BITS  index of current/last granted requester
- `busy`  out  1  high while in GRANT
- `xfer_count`  out  32  total words transferred (only with `ARB_STATS_EN`)

## Operation
- Transfer: a word moves when vld and ack are both high in the same cycle, on either side.
- FSM states IDLE, GRANT; reset → IDLE.
- IDLE: if any `req_vld` high, select first requester at or after round-robin pointer `rr_ptr` (ascending, wrapping NUM_REQ-1→0); register `grant_id`, clear burst counter, go to GRANT. Otherwise stay.
- GRANT: combinational path: `dout_arb2interface` = granted word, `vld_arb2interface` = `req_vld[grant_id]`, `req_ack[grant_id]` = `ack_interface2arb`; all other `req_ack` bits 0.
- Burst counter width clog2(BURST_LEN+1); increments on each transfer.
- Release (→ IDLE, `rr_ptr` ← grant_id+1 mod NUM_REQ) when either: transfer occurs and counter reaches BURST_LEN; or `req_vld[grant_id]` is low (no transfer that cycle).
- In IDLE: `vld_arb2interface`=0, `dout_arb2interface`=0, all `req_ack`=0; `grant_id` holds last value.
- `ack_interface2arb` while output vld low has no effect.
- Requester deasserting vld mid-burst loses grant; words not yet acked remain its responsibility.

## Timing
- Reset values: `req_ack`=0, `vld_arb2interface`=0, `dout_arb2interface`=0, `grant_id`=0, `busy`=0, `rr_ptr`=0, `xfer_count`=0.
- Reset asserted mid-burst: all of the above immediately (async), FSM IDLE; no partial state survives.
- Arbitration latency: `req_vld` high in IDLE cycle t → GRANT from t+1; first transfer earliest in cycle t+1.
- Data/vld/ack path in GRANT is zero-latency combinational (no register between requester and interface).
- Every grant release costs exactly one IDLE cycle; peak throughput BURST_LEN/(BURST_LEN+1) with continuous traffic.
- Lone requester with continuous vld is re-granted after the one idle cycle.
- `busy` registered, equals (state==GRANT).

## Configuration
- `ARB_STATS_EN` defined: `xfer_count` port present; increments by 1 on every interface-side transfer, wraps 0xFFFFFFFF→0, cleared only by reset.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: hold `reset`=1 with all `req_vld`=1 → all outputs 0, `busy`=0; release → GRANT to requester 0 next cycle.
- Single burst: req 2 vld continuously, interface ack=1, BURST_LEN=16 → exactly 16 words from req 2, one IDLE cycle, then req 2 re-granted.
- Round-robin: all four vld, ack=1 → grant order 0,1,2,3,0, 16 words each, one gap cycle between grants.
- Backpressure: ack toggles 1/0 during req 1 burst → words delivered in order, no duplicates/drops, release after 16th accepted word.
- Early release: req 3 drops vld after 5 words while req 0 pending → one IDLE cycle, grant_id=0, `rr_ptr` was 0.
- Stats (`ARB_STATS_EN`): preload traffic of 40 words → `xfer_count`=40; async reset mid-burst → `xfer_count`=0, `vld_arb2interface`=0 same cycle.

Source files
------------

// File: rtl/leaf_stream_arbiter.sv
// Round-robin arbiter that shares one leaf-interface input stream among NUM_REQ producers.
// Define ARB_STATS_EN to add the xfer_count port, which counts transferred words.
//
// state | meaning
// IDLE  | no grant; selects the next requester at or after rr_ptr
// GRANT | grant_id owns the interface for up to BURST_LEN words
module leaf_stream_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 32,
    parameter int REQ_ID_BITS  = 2,
    parameter int BURST_LEN    = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_din,
    input  logic [NUM_REQ-1:0]              req_vld,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [PAYLOAD_BITS-1:0]         dout_arb2interface,
    output logic                            vld_arb2interface,
    input  logic                            ack_interface2arb,
    output logic [REQ_ID_BITS-1:0]          grant_id,
    output logic                            busy
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]                     xfer_count
`endif
);

    localparam int CNT_BITS = $clog2(BURST_LEN + 1);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(BURST_LEN - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [REQ_ID_BITS-1:0]  rr_ptr;
    logic [REQ_ID_BITS-1:0]  rr_ptr_nxt;
    logic [REQ_ID_BITS-1:0]  grant_nxt;
    logic [REQ_ID_BITS-1:0]  sel_id;
    logic [REQ_ID_BITS-1:0]  ptr_after_grant;
    logic [CNT_BITS-1:0]     burst_cnt;
    logic [CNT_BITS-1:0]     burst_cnt_nxt;
    logic                    any_vld;
    logic                    g_vld;
    logic [PAYLOAD_BITS-1:0] g_word;

    // Rotating priority search: first valid requester at or after rr_ptr.
    always_comb begin : rr_select
        int cand;
        sel_id  = rr_ptr;
        any_vld = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any_vld && (cand == i) && req_vld[i]) begin
                    any_vld = 1'b1;
                    sel_id  = REQ_ID_BITS'(i);
                end
            end
        end
    end

    always_comb begin
        g_vld  = 1'b0;
        g_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == REQ_ID_BITS'(i)) begin
                g_vld  = req_vld[i];
                g_word = req_din[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    assign ptr_after_grant = (int'(grant_id) >= NUM_REQ - 1) ? '0 : grant_id + 1'b1;

    always_comb begin
        state_nxt          = state;
        grant_nxt          = grant_id;
        rr_ptr_nxt         = rr_ptr;
        burst_cnt_nxt      = burst_cnt;
        req_ack            = '0;
        dout_arb2interface = '0;
        vld_arb2interface  = 1'b0;
        case (state)
            IDLE: begin
                if (any_vld) begin
                    state_nxt     = GRANT;
                    grant_nxt     = sel_id;
                    burst_cnt_nxt = '0;
                end
            end
            GRANT: begin
                vld_arb2interface  = g_vld;
                dout_arb2interface = g_word;
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ack[i] = (grant_id == REQ_ID_BITS'(i)) && ack_interface2arb;
                end
                if (!g_vld) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = ptr_after_grant;
                end else if (ack_interface2arb) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                    if (burst_cnt == LAST_CNT) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = ptr_after_grant;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_id  <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            busy      <= (state_nxt == GRANT);
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_count <= '0;
        end else if (vld_arb2interface && ack_interface2arb) begin
            xfer_count <= xfer_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_leaf_stream_arbiter.sv
// Self-checking bench for leaf_stream_arbiter: scoreboard of expected words plus a cycle table.
// Build with ARB_STATS_EN defined to also check xfer_count.
module tb_leaf_stream_arbiter;
    localparam int NR = 4;
    localparam int PB = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR*PB-1:0] req_din;
    logic [NR-1:0]   req_vld;
    logic [NR-1:0]   req_ack;
    logic [PB-1:0]   dout;
    logic            vld_out;
    logic            ack_in;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef ARB_STATS_EN
    logic [31:0]     xfer_count;
`endif

    leaf_stream_arbiter #(.NUM_REQ(NR), .PAYLOAD_BITS(PB), .REQ_ID_BITS(2), .BURST_LEN(16)) dut (
        .clk(clk),
        .reset(reset),
        .req_din(req_din),
        .req_vld(req_vld),
        .req_ack(req_ack),
        .dout_arb2interface(dout),
        .vld_arb2interface(vld_out),
        .ack_interface2arb(ack_in),
        .grant_id(grant_id),
        .busy(busy)
`ifdef ARB_STATS_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] word;
    } sb_t;

    typedef struct {
        logic [3:0] vld;
        logic       ack;
        logic       busy;
        logic       vout;
        logic [1:0] gid;
        logic [3:0] rack;
    } vec_t;

    sb_t         sbq[$];
    vec_t        tbl[11];
    logic [15:0] seq[NR];
    logic [15:0] exp_seq[NR];
    int          checks = 0;
    int          errors = 0;
    int          tot;
    int          ncyc;

    function automatic logic [31:0] word_of(input int id, input logic [15:0] s);
        return (32'(id) << 24) | 32'(s);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_din();
        for (int i = 0; i < NR; i++) req_din[i*PB +: PB] = word_of(i, seq[i]);
    endtask

    task automatic push_exp(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            sbq.push_back('{id: 2'(id), word: word_of(id, exp_seq[id])});
            exp_seq[id]++;
        end
    endtask

    // Called just after a negedge with inputs applied; returns at the next negedge.
    task automatic cycle();
        logic [NR-1:0] xf;
        logic [NR-1:0] e_ack;
        logic          e_vld;
        logic [31:0]   e_dout;
        sb_t           e;
        #1;
        xf = req_vld & req_ack;
        if (busy) begin
            e_ack  = ack_in ? (4'b0001 << grant_id) : 4'b0000;
            e_vld  = req_vld[grant_id];
            e_dout = req_din[grant_id*PB +: PB];
        end else begin
            e_ack  = '0;
            e_vld  = 1'b0;
            e_dout = '0;
        end
        check("path_ack", 32'(req_ack), 32'(e_ack));
        check("path_vld", 32'(vld_out), 32'(e_vld));
        check("path_dout", dout, e_dout);
        if (vld_out && ack_in) begin
            tot++;
            if (sbq.size() == 0) begin
                check("sb_unexpected_word", dout, 32'hDEAD_BEEF);
            end else begin
                e = sbq.pop_front();
                check("sb_word", dout, e.word);
                check("sb_id", 32'(grant_id), 32'(e.id));
            end
        end
        @(posedge clk);
        for (int i = 0; i < NR; i++) if (xf[i]) seq[i]++;
        drive_din();
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{4'b1000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000};
        tbl[1]  = '{4'b1001, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[2]  = '{4'b1001, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[3]  = '{4'b1001, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[4]  = '{4'b1001, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[5]  = '{4'b1001, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};
        tbl[6]  = '{4'b0001, 1'b1, 1'b1, 1'b0, 2'd3, 4'b1000};
        tbl[7]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000};
        tbl[8]  = '{4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001};
        tbl[9]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000};
        tbl[10] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};

        for (int i = 0; i < NR; i++) begin
            seq[i]     = '0;
            exp_seq[i] = '0;
        end
        reset   = 1'b1;
        req_vld = '1;
        ack_in  = 1'b1;
        drive_din();

        // reset held with every requester valid
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ack", 32'(req_ack), 0);
        check("rst_vld", 32'(vld_out), 0);
        check("rst_dout", dout, 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;

        // round robin over all four, continuous ack
        push_exp(0, 16); push_exp(1, 16); push_exp(2, 16); push_exp(3, 16); push_exp(0, 16);
        tot = 0; ncyc = 0;
        while (tot < 80 && ncyc < 300) begin
            cycle();
            ncyc++;
            if (ncyc == 1) begin
                check("rr_first_busy", 32'(busy), 1);
                check("rr_first_grant", 32'(grant_id), 0);
            end
        end
        check("rr_words", tot, 80);
        check("rr_cycles", ncyc, 85);
        check("rr_release_idle", 32'(busy), 0);
        check("rr_sb_empty", sbq.size(), 0);
        req_vld = '0;

        // lone requester 2: burst, one idle cycle, re-grant
        req_vld = 4'b0100;
        push_exp(2, 32);
        tot = 0; ncyc = 0;
        while (tot < 32 && ncyc < 200) begin
            cycle();
            ncyc++;
        end
        check("single_words", tot, 32);
        check("single_cycles", ncyc, 34);
        check("single_busy", 32'(busy), 0);
        check("single_grant", 32'(grant_id), 2);
        req_vld = '0;

        // requester 1 under alternating backpressure
        req_vld = 4'b0010;
        push_exp(1, 16);
        tot = 0; ncyc = 0;
        while (tot < 16 && ncyc < 200) begin
            ack_in = (ncyc % 2 == 0);
            cycle();
            ncyc++;
        end
        check("bp_words", tot, 16);
        check("bp_cycles", ncyc, 33);
        check("bp_release", 32'(busy), 0);
        check("bp_grant", 32'(grant_id), 1);
        req_vld = '0;
        ack_in  = 1'b1;

        // requester 3 drops out after five words while requester 0 waits
        push_exp(3, 5);
        push_exp(0, 1);
        tot = 0;
        for (int r = 0; r < 11; r++) begin
            req_vld = tbl[r].vld;
            ack_in  = tbl[r].ack;
            #1;
            check($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
            check($sformatf("tbl%0d_vld", r), 32'(vld_out), 32'(tbl[r].vout));
            check($sformatf("tbl%0d_grant", r), 32'(grant_id), 32'(tbl[r].gid));
            check($sformatf("tbl%0d_ack", r), 32'(req_ack), 32'(tbl[r].rack));
            cycle();
        end
        check("tbl_words", tot, 6);
        check("tbl_sb_empty", sbq.size(), 0);

        // fresh reset, 40 words, then async reset mid-burst
        reset = 1'b1;
        #1;
        check("rst2_busy", 32'(busy), 0);
        @(negedge clk);
        reset   = 1'b0;
        req_vld = 4'b0011;
        ack_in  = 1'b1;
        push_exp(0, 16); push_exp(1, 16); push_exp(0, 8);
        tot = 0; ncyc = 0;
        while (tot < 40 && ncyc < 200) begin
            cycle();
            ncyc++;
        end
        check("st_words", tot, 40);
        check("st_cycles", ncyc, 43);
        #1;
        check("st_midburst_vld", 32'(vld_out), 1);
        check("st_midburst_grant", 32'(grant_id), 0);
`ifdef ARB_STATS_EN
        check("st_xfer_count", xfer_count, 40);
`endif
        reset = 1'b1;
        #1;
        check("async_vld", 32'(vld_out), 0);
        check("async_busy", 32'(busy), 0);
        check("async_dout", dout, 0);
        check("async_req_ack", 32'(req_ack), 0);
        check("async_grant", 32'(grant_id), 0);
`ifdef ARB_STATS_EN
        check("async_xfer_count", xfer_count, 0);
`endif
        check("final_sb_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
